// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// the default bus timeout and the legality check applied at acceptance.
package lsu_pkg;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    // RV32I funct3 codes for loads
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // RV32I funct3 codes for stores
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    // True when the op must be rejected without touching memory:
    // unknown width code, unsigned store, or a misaligned halfword/word.
    function automatic logic op_illegal(input logic       is_store,
                                        input logic [2:0] f3,
                                        input logic [1:0] addr_lo);
        logic bad;
        case (f3)
            F3_LB:          bad = 1'b0;
            F3_LH:          bad = addr_lo[0];
            F3_LW:          bad = (addr_lo != 2'b00);
            F3_LBU:         bad = is_store;
            F3_LHU:         bad = is_store | addr_lo[0];
            default:        bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: builds the write mask and replicated write data for
// the memory port, and extracts/extends the load result from read data.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        op_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] r_data,
    output logic [3:0]  masking,
    output logic [31:0] w_data,
    output logic [31:0] load_value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword lanes out of the read word.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = r_data[7:0];
            2'd1:    byte_sel = r_data[15:8];
            2'd2:    byte_sel = r_data[23:16];
            default: byte_sel = r_data[31:24];
        endcase
        // Halfwords only reach memory when aligned, so addr_lo[1] selects the lane.
        half_sel = addr_lo[1] ? r_data[31:16] : r_data[15:0];
    end

    // Width decode: mask, replicated store data and extended load value.
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // case below leaves a variable unassigned and infers a latch.
        masking    = 4'b0000;
        w_data     = 32'h0;
        load_value = 32'h0;
        case (funct3[1:0])
            2'b00: begin
                masking = 4'b0001 << addr_lo;
                if (op_store) w_data = {4{store_data[7:0]}};
                load_value = funct3[2] ? {24'h0, byte_sel}
                                       : {{24{byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                masking = 4'b0011 << addr_lo;
                if (op_store) w_data = {2{store_data[15:0]}};
                load_value = funct3[2] ? {16'h0, half_sel}
                                       : {{16{half_sel[15]}}, half_sel};
            end
            2'b10: begin
                masking = 4'b1111;
                if (op_store) w_data = store_data;
                load_value = r_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core op at a time, issues it on a simple
// request/valid memory port and returns a one-cycle done (and err) pulse.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    // core side
    input  logic        op_valid,
    input  logic        op_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        err,
    // memory side
    output logic        request,
    output logic        we_re,
    output logic [3:0]  masking,
    output logic [7:0]  address,
    output logic [31:0] w_data,
    input  logic        valid,
    input  logic [31:0] r_data
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_q, state_d;
    logic             err_d, err_q;
    logic [CNT_W-1:0] cnt_q;

    logic             op_store_q;
    logic [2:0]       funct3_q;
    logic [9:0]       addr_q;
    logic [31:0]      store_data_q;
    logic [31:0]      load_q;

    logic             in_access;
    logic [3:0]       mask_raw;
    logic [31:0]      wdata_raw;
    logic [31:0]      load_value;

    // Only the word index within the 1 KiB window reaches the memory port.
    logic             unused_addr_hi;
    assign unused_addr_hi = ^addr[31:10];

    lsu_align u_align (
        .op_store   (op_store_q),
        .funct3     (funct3_q),
        .addr_lo    (addr_q[1:0]),
        .store_data (store_data_q),
        .r_data     (r_data),
        .masking    (mask_raw),
        .w_data     (wdata_raw),
        .load_value (load_value)
    );

    // Next-state logic; err_d flags transitions into RESP that are failures.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    if (op_illegal(op_store, funct3, addr[1:0])) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (valid) begin
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, error flag and access-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            err_q   <= err_d;
            cnt_q   <= (state_q == ST_ACCESS) ? cnt_q + 1'b1 : '0;
        end
    end

    // Capture the op on acceptance and the load result on the valid edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset too, because they feed
            // outputs that must read zero while reset is asserted.
            op_store_q   <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= 10'h0;
            store_data_q <= 32'h0;
            load_q       <= 32'h0;
        end else begin
            if (state_q == ST_IDLE && op_valid) begin
                op_store_q   <= op_store;
                funct3_q     <= funct3;
                addr_q       <= addr[9:0];
                store_data_q <= store_data;
            end
            // Holds the result only through RESP; zero otherwise (stores, timeouts).
            load_q <= (state_q == ST_ACCESS && valid && !op_store_q) ? load_value : 32'h0;
        end
    end

    // Memory-port and core-side outputs, quiet outside their active state.
    always_comb begin
        in_access = (state_q == ST_ACCESS);
        request   = in_access;
        we_re     = in_access & op_store_q;
        masking   = in_access ? mask_raw    : 4'b0000;
        address   = in_access ? addr_q[9:2] : 8'h00;
        w_data    = in_access ? wdata_raw   : 32'h0;
        busy      = in_access;
        done      = (state_q == ST_RESP);
        err       = err_q;
        load_data = load_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: drives and samples on the falling edge.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid, op_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        busy, done, err;
    logic [31:0] load_data;
    logic        request, we_re;
    logic [3:0]  masking;
    logic [7:0]  address;
    logic [31:0] w_data;
    logic        valid;
    logic [31:0] r_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid   (op_valid),
        .op_store   (op_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .err        (err),
        .request    (request),
        .we_re      (we_re),
        .masking    (masking),
        .address    (address),
        .w_data     (w_data),
        .valid      (valid),
        .r_data     (r_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Legal op: op_valid held until done, valid returned after wait_n extra cycles.
    task automatic run_op(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input int wait_n,
                          input logic [31:0] rd, input logic [3:0] exp_mask,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_load);
        op_valid = 1'b1; op_store = st; funct3 = f3; addr = a; store_data = sd;
        @(negedge clk);
        check({tag, "_req"},   request,  1);
        check({tag, "_busy"},  busy,     1);
        check({tag, "_we"},    we_re,    st);
        check({tag, "_addr"},  address,  a[9:2]);
        check({tag, "_mask"},  masking,  exp_mask);
        check({tag, "_wdata"}, w_data,   exp_wdata);
        for (int i = 0; i < wait_n; i++) begin
            @(negedge clk);
            check({tag, "_hold"}, {request, done, masking}, {2'b10, exp_mask});
        end
        valid = 1'b1; r_data = rd;
        @(negedge clk);
        check({tag, "_done"},  done,      1);
        check({tag, "_err"},   err,       0);
        check({tag, "_ld"},    load_data, exp_load);
        check({tag, "_rq0"},   {request, busy}, 0);
        valid = 1'b0; r_data = 32'h0; op_valid = 1'b0;
        @(negedge clk);
        check({tag, "_idle"},  {done, err, request}, 0);
    endtask

    // Illegal op: rejected without a memory request, err with done next cycle.
    task automatic run_err(input string tag, input logic st, input logic [2:0] f3,
                           input logic [31:0] a);
        op_valid = 1'b1; op_store = st; funct3 = f3; addr = a; store_data = 32'h1234_5678;
        @(negedge clk);
        check({tag, "_rq"},   {request, busy}, 0);
        check({tag, "_done"}, done,      1);
        check({tag, "_err"},  err,       1);
        check({tag, "_ld"},   load_data, 0);
        op_valid = 1'b0;
        @(negedge clk);
        check({tag, "_idle"}, {done, err, request}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_cycles;
        rst_n = 1'b0; op_valid = 1'b0; op_store = 1'b0; funct3 = 3'b000;
        addr = 32'h0; store_data = 32'h0; valid = 1'b0; r_data = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_port", {request, we_re, masking, address}, 0);
        check("rst_wdata", w_data, 0);
        check("rst_core", {busy, done, err}, 0);
        check("rst_ld", load_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // valid with no request in flight must be ignored
        valid = 1'b1; r_data = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        check("stray_valid", {done, err, request, busy}, 0);
        valid = 1'b0; r_data = 32'h0;

        run_op("sw",  1'b1, F3_SW,  32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0,         4'b1111, 32'hDEAD_BEEF, 32'h0);
        run_op("sb",  1'b1, F3_SB,  32'h0000_0013, 32'h0000_00A5, 0, 32'h0,         4'b1000, 32'hA5A5_A5A5, 32'h0);
        run_op("sh",  1'b1, F3_SH,  32'h0000_0002, 32'h1234_ABCD, 1, 32'h0,         4'b1100, 32'hABCD_ABCD, 32'h0);
        run_op("lb",  1'b0, F3_LB,  32'h0000_0022, 32'h0,         0, 32'h0080_0000, 4'b0100, 32'h0,         32'hFFFF_FF80);
        run_op("lbu", 1'b0, F3_LBU, 32'h0000_0022, 32'h0,         0, 32'h0080_0000, 4'b0100, 32'h0,         32'h0000_0080);
        run_op("lh",  1'b0, F3_LH,  32'h0000_0022, 32'h0,         0, 32'h8001_0000, 4'b1100, 32'h0,         32'hFFFF_8001);
        run_op("lhu", 1'b0, F3_LHU, 32'h0000_0022, 32'h0,         2, 32'h8001_0000, 4'b1100, 32'h0,         32'h0000_8001);
        run_op("lb1", 1'b0, F3_LB,  32'h0000_0101, 32'h0,         0, 32'h0000_7F00, 4'b0010, 32'h0,         32'h0000_007F);
        run_op("lw",  1'b0, F3_LW,  32'h0000_03FC, 32'h0,         3, 32'h1234_5678, 4'b1111, 32'h0,         32'h1234_5678);

        run_err("lw_mis",  1'b0, F3_LW,  32'h0000_0006);
        run_err("lh_mis",  1'b0, F3_LH,  32'h0000_0021);
        run_err("ld_011",  1'b0, 3'b011, 32'h0000_0000);
        run_err("sbu_100", 1'b1, 3'b100, 32'h0000_0000);

        // op_valid held through RESP is not taken until the following IDLE cycle
        op_valid = 1'b1; op_store = 1'b1; funct3 = F3_SW; addr = 32'h20; store_data = 32'h0BAD_F00D;
        @(negedge clk);
        valid = 1'b1;
        @(negedge clk);
        check("b2b_done", done, 1);
        valid = 1'b0;
        @(negedge clk);
        check("b2b_idle", {request, busy, done}, 0);
        @(negedge clk);
        check("b2b_req2", request, 1);
        op_valid = 1'b0; valid = 1'b1;
        @(negedge clk);
        check("b2b_done2", done, 1);
        valid = 1'b0;
        @(negedge clk);

        // timeout: valid never returned
        op_valid = 1'b1; op_store = 1'b0; funct3 = F3_LW; addr = 32'h40;
        req_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) break;
            if (request) req_cycles++;
        end
        check("to_cycles", req_cycles, 16);
        check("to_done", {done, err}, 2'b11);
        check("to_ld", load_data, 0);
        check("to_req", request, 0);
        op_valid = 1'b0;
        @(negedge clk);
        check("to_idle", {done, err}, 0);

        // reset in the third ACCESS cycle abandons the op
        op_valid = 1'b1; op_store = 1'b0; funct3 = F3_LW; addr = 32'h80;
        repeat (3) @(negedge clk);
        check("rs_req_before", request, 1);
        op_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rs_req_now", {request, busy, done, err}, 0);
        check("rs_port", {masking, address}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rs_no_done", {done, err, request}, 0);
        end
        run_op("rs_sw", 1'b1, F3_SW, 32'h0000_0010, 32'hCAFE_0001, 0, 32'h0, 4'b1111, 32'hCAFE_0001, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
